shiftrows_pipe: RTL and testbench
=================================

SHIFTROWS_PIPE -- requirements
Module: shiftrows_pipe

Interface
REQ-001 SHALL have parameter NB, default 4, meaning state columns (legal 4, 6, 8; Rijndael block 32*NB bits).
REQ-002 SHALL have parameter DEPTH, default 2, meaning pipeline register stages (legal 1..4).
REQ-003 SHALL have parameter TAG_W, default 4, meaning width of the sideband tag carried with each block.
REQ-004 SHALL have port clk, input, 1, the single clock; all logic rising-edge.
REQ-005 SHALL have port rst_n, input, 1, the reset: synchronous, active-low.
REQ-006 SHALL have port in_valid, input, 1, input block present.
REQ-007 SHALL have port in_ready, output, 1, block accepted when in_valid and in_ready are both high.
REQ-008 SHALL have port in_inv, input, 1: 0 = forward ShiftRows, 1 = InvShiftRows, sampled per block.
REQ-009 SHALL have port in_tag, input, TAG_W, sideband passed through unchanged.
REQ-010 SHALL have port data_in, input, 32*NB, state block.
REQ-011 SHALL have port out_valid, output, 1, result present.
REQ-012 SHALL have port out_ready, input, 1, downstream accepts.
REQ-013 SHALL have port out_tag, output, TAG_W, tag of the presented result.
REQ-014 SHALL have port data_out, output, 32*NB, permuted state.

Function
REQ-015 SHALL use this byte layout: byte k = r + 4c (row r 0..3, column c) occupies bits [32*NB-1-8k -: 8].
REQ-016 SHALL use row offsets s(r): NB=4 or 6 -> 0,1,2,3; NB=8 -> 0,1,3,4.
REQ-017 SHALL compute forward as out(r,c) = in(r,(c+s(r)) mod NB) and inverse as out(r,c) = in(r,(c-s(r)) mod NB), combinationally before stage 1.
REQ-018 SHALL advance each stage holding valid data when the next stage is empty or is itself advancing; the last stage advances on out_ready.
REQ-019 SHALL drive in_ready high iff stage 1 is empty or advancing this cycle; there SHALL be no combinational path from in_valid to in_ready.
REQ-020 SHALL give a latency of exactly DEPTH cycles from acceptance to out_valid when out_ready is held high, at a throughput of one block per cycle.
REQ-021 SHALL hold data_out and out_tag stable while out_valid=1 and out_ready=0; no block lost or duplicated under any backpressure pattern.
REQ-022 SHALL, when the pipeline is full and out_ready=1 in the same cycle as in_valid=1, accept and retire simultaneously with no bubble.
REQ-023 SHALL allow in_inv to change per block; mixed-mode streams exit in order, each transformed per its own in_inv.

Reset
REQ-024 SHALL, with rst_n low at a clock edge, clear all stage valids, data, and tags to 0; out_valid=0, data_out=0, out_tag=0.
REQ-025 SHALL discard in-flight blocks on reset mid-operation; in_ready=1 on the first cycle after rst_n returns high.

Configuration
REQ-026 SHALL, with macro SHIFTROWS_PIPE_STATS_EN defined, add output port blk_count (32 bits): count of completed output handshakes, saturating at 0xFFFFFFFF, reset to 0.
REQ-027 SHALL, without SHIFTROWS_PIPE_STATS_EN, have no blk_count port and no counter logic.

Structure
REQ-028 SHALL place the row-offset function s(NB,r), the byte-index function, and the legal-NB check in shared package aes_pkg.
REQ-029 SHALL implement the combinational permutation in one sub-module, rowshift_perm (parameters NB; ports inv, din, dout); stage registers and handshake stay in shiftrows_pipe.
REQ-030 SHALL reject illegal NB or DEPTH at elaboration.

Verification
REQ-031 SHALL cover: NB=4, forward, data_in=0x000102030405060708090a0b0c0d0e0f, out_ready=1 -> data_out=0x00050a0f04090e03080d02070c01060b after DEPTH cycles.
REQ-032 SHALL cover: NB=4, inverse of 0x00050a0f04090e03080d02070c01060b -> 0x000102030405060708090a0b0c0d0e0f; tag 0xA preserved.
REQ-033 SHALL cover: NB=8, forward of the ascending byte vector 0x00..0x1f -> bytes 0..3 of the result = 0x00,0x05,0x0e,0x13.
REQ-034 SHALL cover: 16 back-to-back blocks with alternating in_inv and random out_ready stalls -> all 16 exit in order and match the reference model; no drops or duplicates.
REQ-035 SHALL cover: rst_n low for 1 cycle with the pipeline full -> out_valid=0 next cycle, in_ready=1, no stale block emitted.
REQ-036 SHALL cover: with SHIFTROWS_PIPE_STATS_EN defined, 5 completed handshakes -> blk_count=5; blk_count preloaded to 0xFFFFFFFF stays saturated.

Source files
------------

// File: rtl/aes_pkg.sv
// Shared Rijndael state helpers: row offsets, byte placement and NB legality.
package aes_pkg;

    // Row offset for ShiftRows; the 256-bit block widens rows 2 and 3.
    function automatic int shift_amt(input int nb, input int r);
        if (nb == 8) return (r < 2) ? r : r + 1;
        return r;
    endfunction

    // MSB position of state byte k (k = row + 4*col), byte 0 in the top bits.
    function automatic int byte_msb(input int nb, input int k);
        return 32 * nb - 1 - 8 * k;
    endfunction

    // Rijndael block sizes supported by this datapath.
    function automatic bit nb_legal(input int nb);
        return (nb == 4) || (nb == 6) || (nb == 8);
    endfunction

endpackage

// File: rtl/rowshift_perm.sv
// Combinational forward / inverse ShiftRows byte permutation for an NB-column state.
module rowshift_perm
    import aes_pkg::*;
#(
    parameter int NB = 4
) (
    input  logic            inv,
    input  logic [32*NB-1:0] din,
    output logic [32*NB-1:0] dout
);

    // Pure wiring: each output byte picks one of two source bytes in its own row.
    for (genvar r = 0; r < 4; r++) begin : g_row
        for (genvar c = 0; c < NB; c++) begin : g_col
            localparam int S     = shift_amt(NB, r);
            localparam int DST   = byte_msb(NB, r + 4 * c);
            localparam int SRC_F = byte_msb(NB, r + 4 * ((c + S) % NB));
            localparam int SRC_I = byte_msb(NB, r + 4 * ((c + NB - S) % NB));
            assign dout[DST -: 8] = inv ? din[SRC_I -: 8] : din[SRC_F -: 8];
        end
    end

endmodule

// File: rtl/shiftrows_pipe.sv
// ShiftRows / InvShiftRows with a DEPTH-stage elastic pipeline and a tag sideband.
// Optional: define SHIFTROWS_PIPE_STATS_EN to add the saturating blk_count output.
module shiftrows_pipe
    import aes_pkg::*;
#(
    parameter int NB    = 4,
    parameter int DEPTH = 2,
    parameter int TAG_W = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             in_inv,
    input  logic [TAG_W-1:0] in_tag,
    input  logic [32*NB-1:0] data_in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [TAG_W-1:0] out_tag,
    output logic [32*NB-1:0] data_out
`ifdef SHIFTROWS_PIPE_STATS_EN
    ,
    output logic [31:0]      blk_count
`endif
);

    localparam int W = 32 * NB;

    if (!nb_legal(NB)) begin : g_bad_nb
        $error("shiftrows_pipe: NB must be 4, 6 or 8");
    end
    if (DEPTH < 1 || DEPTH > 4) begin : g_bad_depth
        $error("shiftrows_pipe: DEPTH must be 1..4");
    end

    logic [W-1:0] perm;

    rowshift_perm #(.NB(NB)) u_perm (
        .inv  (in_inv),
        .din  (data_in),
        .dout (perm)
    );

    logic [DEPTH-1:0]            vld_q, vld_d, adv;
    logic [DEPTH-1:0][W-1:0]     data_q, data_d;
    logic [DEPTH-1:0][TAG_W-1:0] tag_q, tag_d;

    // Advance decisions ripple back from the output so a full pipe can move in lockstep.
    always_comb begin
        adv = '0;
        adv[DEPTH-1] = vld_q[DEPTH-1] && out_ready;
        for (int i = DEPTH - 2; i >= 0; i--) begin
            adv[i] = vld_q[i] && (!vld_q[i+1] || adv[i+1]);
        end
    end

    // Depends only on stage state and out_ready, never on in_valid.
    assign in_ready = !vld_q[0] || adv[0];

    // Next state: a stage loads from its upstream neighbour, empties when it advances, else holds.
    always_comb begin
        vld_d  = vld_q;
        data_d = data_q;
        tag_d  = tag_q;
        if (in_valid && in_ready) begin
            vld_d[0]  = 1'b1;
            data_d[0] = perm;
            tag_d[0]  = in_tag;
        end else if (adv[0]) begin
            vld_d[0] = 1'b0;
        end
        for (int i = 1; i < DEPTH; i++) begin
            if (adv[i-1]) begin
                vld_d[i]  = 1'b1;
                data_d[i] = data_q[i-1];
                tag_d[i]  = tag_q[i-1];
            end else if (adv[i]) begin
                vld_d[i] = 1'b0;
            end
        end
    end

    // Stage registers; reset clears everything so outputs read as zero.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            vld_q  <= '0;
            data_q <= '0;
            tag_q  <= '0;
        end else begin
            vld_q  <= vld_d;
            data_q <= data_d;
            tag_q  <= tag_d;
        end
    end

    assign out_valid = vld_q[DEPTH-1];
    assign data_out  = data_q[DEPTH-1];
    assign out_tag   = tag_q[DEPTH-1];

`ifdef SHIFTROWS_PIPE_STATS_EN
    logic [31:0] cnt_q, cnt_d;

    // Count output handshakes, sticking at all-ones.
    always_comb begin
        cnt_d = cnt_q;
        if (out_valid && out_ready && cnt_q != 32'hFFFF_FFFF) cnt_d = cnt_q + 32'd1;
    end

    // Counter register.
    always_ff @(posedge clk) begin
        if (!rst_n) cnt_q <= '0;
        else        cnt_q <= cnt_d;
    end

    assign blk_count = cnt_q;
`endif

endmodule

// File: tb/tb_shiftrows_pipe.sv
// Self-checking bench for shiftrows_pipe: directed vectors, random stream with stalls, reset.
module tb_shiftrows_pipe;

    localparam int NB = 4, DEPTH = 2, TAG_W = 4, W = 128;
    localparam int NB8 = 8, DEPTH8 = 3, W8 = 256;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic             rst_n;
    logic             in_valid, in_ready, in_inv, out_valid, out_ready;
    logic [TAG_W-1:0] in_tag, out_tag;
    logic [W-1:0]     data_in, data_out;

    logic             b_in_valid, b_in_ready, b_in_inv, b_out_valid, b_out_ready;
    logic [TAG_W-1:0] b_in_tag, b_out_tag;
    logic [W8-1:0]    b_data_in, b_data_out;

`ifdef SHIFTROWS_PIPE_STATS_EN
    logic [31:0] blk_count, b_blk_count;
`endif

    shiftrows_pipe #(.NB(NB), .DEPTH(DEPTH), .TAG_W(TAG_W)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_inv(in_inv), .in_tag(in_tag), .data_in(data_in), .out_valid(out_valid),
        .out_ready(out_ready), .out_tag(out_tag), .data_out(data_out)
`ifdef SHIFTROWS_PIPE_STATS_EN
        , .blk_count(blk_count)
`endif
    );

    shiftrows_pipe #(.NB(NB8), .DEPTH(DEPTH8), .TAG_W(TAG_W)) dut8 (
        .clk(clk), .rst_n(rst_n), .in_valid(b_in_valid), .in_ready(b_in_ready),
        .in_inv(b_in_inv), .in_tag(b_in_tag), .data_in(b_data_in), .out_valid(b_out_valid),
        .out_ready(b_out_ready), .out_tag(b_out_tag), .data_out(b_data_out)
`ifdef SHIFTROWS_PIPE_STATS_EN
        , .blk_count(b_blk_count)
`endif
    );

    int n_tests = 0, n_fail = 0;

    task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference: view the block as a 4 x nb byte matrix and rotate each row.
    function automatic logic [255:0] ref_sr(input int nb, input logic [255:0] din, input bit inv);
        logic [7:0]   st [4][8];
        logic [255:0] res;
        int           sh [4];
        int           src;
        res = '0;
        if (nb == 8) sh = '{0, 1, 3, 4};
        else         sh = '{0, 1, 2, 3};
        for (int c = 0; c < nb; c++)
            for (int r = 0; r < 4; r++)
                st[r][c] = din[32*nb-1-8*(r+4*c) -: 8];
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < nb; c++) begin
                src = inv ? (c - sh[r] + nb) % nb : (c + sh[r]) % nb;
                res[32*nb-1-8*(r+4*c) -: 8] = st[r][src];
            end
        return res;
    endfunction

    typedef struct {
        logic [W-1:0]     d;
        logic [TAG_W-1:0] t;
    } exp_t;

    exp_t             q[$];
    exp_t             mon_e;
    logic [255:0]     mon_r;
    bit               mon_en = 0;
    bit               hold_pend = 0;
    logic [W-1:0]     hold_d;
    logic [TAG_W-1:0] hold_t;
    int               n_ret = 0;

    // Scoreboard on the NB=4 instance: push on accept, pop on retire, check holds under stall.
    always @(negedge clk) begin
        if (mon_en && rst_n) begin
            if (in_valid && in_ready) begin
                mon_r   = ref_sr(NB, {128'b0, data_in}, in_inv);
                mon_e.d = mon_r[W-1:0];
                mon_e.t = in_tag;
                q.push_back(mon_e);
            end
            if (out_valid) begin
                if (hold_pend) begin
                    chk("hold_data", data_out, hold_d);
                    chk("hold_tag", out_tag, hold_t);
                end
                if (out_ready) begin
                    hold_pend = 0;
                    n_ret++;
                    if (q.size() == 0) chk("spurious_out", 1, 0);
                    else begin
                        mon_e = q.pop_front();
                        chk("sb_data", data_out, mon_e.d);
                        chk("sb_tag", out_tag, mon_e.t);
                    end
                end else begin
                    hold_pend = 1;
                    hold_d    = data_out;
                    hold_t    = out_tag;
                end
            end else if (hold_pend) begin
                chk("hold_lost", 0, 1);
                hold_pend = 0;
            end
        end
    end

    // Offer one block until accepted (bounded); returns at posedge+1 after the accept edge.
    task automatic send1(input logic [W-1:0] d, input bit inv, input logic [TAG_W-1:0] t);
        bit acc = 0;
        in_valid = 1; data_in = d; in_inv = inv; in_tag = t;
        for (int k = 0; k < 100 && !acc; k++) begin
            @(negedge clk);
            acc = in_ready;
            @(posedge clk); #1;
        end
        in_valid = 0;
        if (!acc) chk("send_timeout", 0, 1);
    endtask

    task automatic drain(input int budget, input bit rnd);
        for (int k = 0; k < budget && q.size() != 0; k++) begin
            if (rnd) out_ready = ($urandom_range(0, 2) != 0);
            @(posedge clk); #1;
        end
        out_ready = 1;
        chk("drain_empty", q.size(), 0);
    endtask

    // Single block into an empty pipe with out_ready high: check latency, data and tag.
    task automatic run_directed(input string name, input logic [W-1:0] d, input bit inv,
                                input logic [TAG_W-1:0] t, input logic [W-1:0] exp);
        out_ready = 1;
        in_valid = 1; data_in = d; in_inv = inv; in_tag = t;
        @(negedge clk);
        chk({name, "_acc"}, in_ready, 1);
        @(posedge clk); #1;
        in_valid = 0;
        for (int i = 1; i <= DEPTH; i++) begin
            @(negedge clk);
            chk({name, "_lat"}, out_valid, (i == DEPTH));
            if (i < DEPTH) begin @(posedge clk); #1; end
        end
        chk({name, "_data"}, data_out, exp);
        chk({name, "_tag"}, out_tag, t);
        @(posedge clk); #1;
    endtask

    function automatic logic [W-1:0] rnd128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    initial begin
        logic [W8-1:0] v8, r8;
        logic [W-1:0]  d;
        int            idx, cyc, ret0;
        bit            acc, fresh;

        rst_n = 0; in_valid = 0; in_inv = 0; in_tag = 0; data_in = 0; out_ready = 0;
        b_in_valid = 0; b_in_inv = 0; b_in_tag = 0; b_data_in = 0; b_out_ready = 1;

        repeat (2) begin @(posedge clk); #1; end
        @(negedge clk);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_data_out", data_out, 0);
        chk("rst_out_tag", out_tag, 0);
        chk("rst_b_out_valid", b_out_valid, 0);
        @(posedge clk); #1;
        rst_n = 1;
        @(negedge clk);
        chk("rst_in_ready", in_ready, 1);
        @(posedge clk); #1;
        mon_en = 1;

        run_directed("fwd4", 128'h000102030405060708090a0b0c0d0e0f, 0, 4'h3,
                     128'h00050a0f04090e03080d02070c01060b);
        run_directed("inv4", 128'h00050a0f04090e03080d02070c01060b, 1, 4'hA,
                     128'h000102030405060708090a0b0c0d0e0f);

        // NB=8 forward of ascending bytes, then a random inverse
        for (int k = 0; k < 32; k++) v8[255-8*k -: 8] = k[7:0];
        for (int pass = 0; pass < 2; pass++) begin
            if (pass == 1) v8 = {rnd128(), rnd128()};
            b_in_valid = 1; b_data_in = v8; b_in_inv = pass[0]; b_in_tag = 4'h5;
            @(negedge clk);
            chk("nb8_acc", b_in_ready, 1);
            @(posedge clk); #1;
            b_in_valid = 0;
            for (int i = 1; i <= DEPTH8; i++) begin
                @(negedge clk);
                chk("nb8_lat", b_out_valid, (i == DEPTH8));
                if (i < DEPTH8) begin @(posedge clk); #1; end
            end
            r8 = ref_sr(NB8, v8, pass[0]);
            if (pass == 0) chk("nb8_bytes0_3", b_data_out[255 -: 32], 32'h00050e13);
            chk("nb8_full", b_data_out, r8);
            chk("nb8_tag", b_out_tag, 4'h5);
            @(posedge clk); #1;
        end

        // Fill, then accept and retire in the same cycle
        out_ready = 0;
        for (int k = 0; k < DEPTH; k++) send1(rnd128(), k[0], k[3:0]);
        in_valid = 1; data_in = rnd128(); in_inv = 1; in_tag = 4'h9;
        @(negedge clk);
        chk("full_in_ready", in_ready, 0);
        @(posedge clk); #1;
        out_ready = 1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk("no_bubble_rdy", in_ready, 1);
            chk("no_bubble_vld", out_valid, 1);
            @(posedge clk); #1;
            data_in = rnd128(); in_inv = ~in_inv; in_tag = in_tag + 1;
        end
        in_valid = 0;
        drain(50, 0);

        // 16-block mixed-mode stream with random output stalls
        ret0 = n_ret; idx = 0; cyc = 0; fresh = 1;
        while (idx < 16 && cyc < 2000) begin
            if (fresh) begin
                data_in = rnd128(); in_inv = idx[0]; in_tag = $urandom_range(0, 15);
            end
            in_valid  = 1;
            out_ready = ($urandom_range(0, 2) != 0);
            @(negedge clk);
            acc = in_ready;
            @(posedge clk); #1;
            fresh = acc;
            if (acc) idx++;
            cyc++;
        end
        in_valid = 0;
        chk("stream_sent", idx, 16);
        drain(300, 1);
        chk("stream_retired", n_ret - ret0, 16);
        @(negedge clk);
        chk("stream_no_dup", out_valid, 0);
        @(posedge clk); #1;

        // Reset with the pipe full and stalled
        out_ready = 0;
        for (int k = 0; k < DEPTH; k++) send1(rnd128(), 0, 4'hF);
        mon_en = 0;
        q.delete();
        hold_pend = 0;
        rst_n = 0;
        @(posedge clk); #1;
        rst_n = 1;
        @(negedge clk);
        chk("mrst_out_valid", out_valid, 0);
        chk("mrst_in_ready", in_ready, 1);
        chk("mrst_data", data_out, 0);
        chk("mrst_tag", out_tag, 0);
        mon_en = 1;
        @(posedge clk); #1;
        out_ready = 1;
        for (int k = 0; k < DEPTH + 2; k++) begin
            @(negedge clk);
            chk("mrst_no_stale", out_valid, 0);
            @(posedge clk); #1;
        end

`ifdef SHIFTROWS_PIPE_STATS_EN
        for (int k = 0; k < 5; k++) send1(rnd128(), k[0], k[3:0]);
        drain(50, 0);
        @(posedge clk); #1;
        chk("blk_count_5", blk_count, 32'd5);
        force dut.cnt_q = 32'hFFFF_FFFF;
        #1;
        release dut.cnt_q;
        send1(rnd128(), 0, 4'h1);
        drain(50, 0);
        @(posedge clk); #1;
        chk("blk_count_sat", blk_count, 32'hFFFF_FFFF);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
